// File: rtl/blram_arbiter_if.sv
// Bus bundle between the two requesters (A: CPU, B: loader/debug) and the shared blram.
// slave = arbiter view, master = requester/RAM environment view.
interface blram_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/blram_arbiter.sv
// Two-port arbiter sharing the single-port blram; one grant per cycle, read data tagged back to its requester.
// Define BLRAM_ARB_RR_EN for round-robin on contention; otherwise port A has fixed priority.
module blram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  blram_arbiter_if.slave   bus
);

  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_a_wins_tie;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              r_rd_a;
  logic              r_rd_b;

`ifdef BLRAM_ARB_RR_EN
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t r_prio;
  prio_t w_prio_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prio <= PRIO_A;
    end else begin
      r_prio <= w_prio_next;
    end
  end

  // Pointer hands priority to whichever port lost (or did not ask) this cycle.
  always_comb begin
    w_prio_next = r_prio;
    if (w_gnt_a) begin
      w_prio_next = PRIO_B;
    end else if (w_gnt_b) begin
      w_prio_next = PRIO_A;
    end
  end

  assign w_a_wins_tie = (r_prio == PRIO_A);
`else
  assign w_a_wins_tie = 1'b1;
`endif

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (rst) begin
      if (bus.a_req && (!bus.b_req || w_a_wins_tie)) begin
        w_gnt_a = 1'b1;
      end else if (bus.b_req) begin
        w_gnt_b = 1'b1;
      end
    end
  end

  // Idle bus is driven to zero so the RAM never sees a stray write.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_gnt_a) begin
      w_mem_we    = bus.a_we;
      w_mem_addr  = bus.a_addr;
      w_mem_wdata = bus.a_wdata;
    end else if (w_gnt_b) begin
      w_mem_we    = bus.b_we;
      w_mem_addr  = bus.b_addr;
      w_mem_wdata = bus.b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_a <= 1'b0;
      r_rd_b <= 1'b0;
    end else begin
      r_rd_a <= w_gnt_a & ~bus.a_we;
      r_rd_b <= w_gnt_b & ~bus.b_we;
    end
  end

  assign bus.a_gnt     = w_gnt_a;
  assign bus.b_gnt     = w_gnt_b;
  assign bus.a_rvalid  = r_rd_a;
  assign bus.b_rvalid  = r_rd_b;
  assign bus.a_rdata   = bus.mem_rdata;
  assign bus.b_rdata   = bus.mem_rdata;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_blram_arbiter.sv
// Bench for blram_arbiter: a behavioural RAM, a last-winner arbitration model and directed vectors.
module tb_blram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   done = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  blram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  blram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for blram: read-first, one-cycle registered output.
  logic [DATA_W-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Model state: who won last (-1 none, 0 A, 1 B), pending read tags, shadow memory.
  int                lastWinner = -1;
  bit                expRvA = 1'b0;
  bit                expRvB = 1'b0;
  logic [DATA_W-1:0] expDataA = '0;
  logic [DATA_W-1:0] expDataB = '0;
  logic [DATA_W-1:0] shadow [0:DEPTH-1];

  function automatic void modelGrant(output bit ga, output bit gb);
    bit aWinsTie;
`ifdef BLRAM_ARB_RR_EN
    aWinsTie = (lastWinner != 0);
`else
    aWinsTie = 1'b1;
`endif
    ga = 1'b0;
    gb = 1'b0;
    if (rst === 1'b1) begin
      if (bus.a_req && bus.b_req) begin
        ga = aWinsTie;
        gb = !aWinsTie;
      end else begin
        ga = bus.a_req;
        gb = bus.b_req;
      end
    end
  endfunction

  always @(posedge clk) begin
    bit ga, gb;
    modelGrant(ga, gb);
    if (rst !== 1'b1) begin
      lastWinner = -1;
      expRvA = 1'b0;
      expRvB = 1'b0;
    end else begin
      expRvA = ga && !bus.a_we;
      expRvB = gb && !bus.b_we;
      if (ga) begin
        lastWinner = 0;
        if (bus.a_we) shadow[bus.a_addr] = bus.a_wdata;
        else expDataA = shadow[bus.a_addr];
      end else if (gb) begin
        lastWinner = 1;
        if (bus.b_we) shadow[bus.b_addr] = bus.b_wdata;
        else expDataB = shadow[bus.b_addr];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every cycle.
  always @(negedge clk) begin
    bit ga, gb;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    if (!done) begin
      modelGrant(ga, gb);
      we = 1'b0; addr = '0; wdata = '0;
      if (ga) begin
        we = bus.a_we; addr = bus.a_addr; wdata = bus.a_wdata;
      end else if (gb) begin
        we = bus.b_we; addr = bus.b_addr; wdata = bus.b_wdata;
      end
      checkOutput("mdlGntA", 32'(bus.a_gnt), 32'(ga));
      checkOutput("mdlGntB", 32'(bus.b_gnt), 32'(gb));
      checkOutput("mdlMemWe", 32'(bus.mem_we), 32'(we));
      checkOutput("mdlMemAddr", 32'(bus.mem_addr), 32'(addr));
      checkOutput("mdlMemWdata", bus.mem_wdata, wdata);
      checkOutput("mdlRvalidA", 32'(bus.a_rvalid), 32'(expRvA));
      checkOutput("mdlRvalidB", 32'(bus.b_rvalid), 32'(expRvB));
      if (expRvA) checkOutput("mdlRdataA", bus.a_rdata, expDataA);
      if (expRvB) checkOutput("mdlRdataB", bus.b_rdata, expDataB);
    end
  end

  task automatic applyStimulus(input logic r,
                               input logic ar, input logic aw, input int aa, input logic [31:0] ad,
                               input logic br, input logic bw, input int ba, input logic [31:0] bd);
    @(posedge clk);
    #1;
    rst         = r;
    bus.a_req   = ar;
    bus.a_we    = aw;
    bus.a_addr  = ADDR_W'(aa);
    bus.a_wdata = ad;
    bus.b_req   = br;
    bus.b_we    = bw;
    bus.b_addr  = ADDR_W'(ba);
    bus.b_wdata = bd;
  endtask

  initial begin
    bit wantA;
    bit prevA;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]    = 32'h1000_0000 + 32'(i);
      shadow[i] = 32'h1000_0000 + 32'(i);
    end
    rst = 1'b0;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 14'd10; bus.a_wdata = '0;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 14'd20; bus.b_wdata = '0;

    // Reset held with both ports requesting.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 10, 0, 1'b1, 1'b0, 20, 0);
      @(negedge clk);
      checkOutput("rstGntA", 32'(bus.a_gnt), 32'd0);
      checkOutput("rstGntB", 32'(bus.b_gnt), 32'd0);
      checkOutput("rstMemWe", 32'(bus.mem_we), 32'd0);
      checkOutput("rstRvalidA", 32'(bus.a_rvalid), 32'd0);
      checkOutput("rstRvalidB", 32'(bus.b_rvalid), 32'd0);
    end

    // Continuous contention: A reads 10, B reads 20.
    prevA = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 10, 0, 1'b1, 1'b0, 20, 0);
      @(negedge clk);
`ifdef BLRAM_ARB_RR_EN
      wantA = (i % 2 == 0);
`else
      wantA = 1'b1;
`endif
      checkOutput("contGntA", 32'(bus.a_gnt), 32'(wantA));
      checkOutput("contGntB", 32'(bus.b_gnt), 32'(!wantA));
      if (i > 0) begin
        checkOutput("contRvalidA", 32'(bus.a_rvalid), 32'(prevA));
        checkOutput("contRvalidB", 32'(bus.b_rvalid), 32'(!prevA));
        if (prevA) checkOutput("contRdataA", bus.a_rdata, 32'h1000_000A);
        else       checkOutput("contRdataB", bus.b_rdata, 32'h1000_0014);
      end
      prevA = wantA;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);

    // B writes 0xAB to 50, then reads it back.
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 50, 32'h0000_00AB);
    @(negedge clk);
    checkOutput("bWrGnt", 32'(bus.b_gnt), 32'd1);
    checkOutput("bWrMemWe", 32'(bus.mem_we), 32'd1);
    checkOutput("bWrMemAddr", 32'(bus.mem_addr), 32'd50);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 50, 0);
    @(negedge clk);
    checkOutput("bRdGnt", 32'(bus.b_gnt), 32'd1);
    checkOutput("bWrNoRvalid", 32'(bus.b_rvalid), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checkOutput("bRdRvalid", 32'(bus.b_rvalid), 32'd1);
    checkOutput("bRdData", bus.b_rdata, 32'h0000_00AB);
    checkOutput("bRdNoRvalidA", 32'(bus.a_rvalid), 32'd0);

    // Only A requests: back-to-back reads of 0..3.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, k, 0, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      checkOutput("idleGntA", 32'(bus.a_gnt), 32'd1);
      if (k > 0) begin
        checkOutput("idleRvalidA", 32'(bus.a_rvalid), 32'd1);
        checkOutput("idleRdataA", bus.a_rdata, 32'h1000_0000 + 32'(k - 1));
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checkOutput("idleRvalidLast", 32'(bus.a_rvalid), 32'd1);
    checkOutput("idleRdataLast", bus.a_rdata, 32'h1000_0003);

    // A writes 7, B reads it back.
    applyStimulus(1'b1, 1'b1, 1'b1, 7, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 7, 0);
    @(negedge clk);
    checkOutput("aWrNoRvalid", 32'(bus.a_rvalid), 32'd0);
    checkOutput("bRd7Gnt", 32'(bus.b_gnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checkOutput("bRd7Rvalid", 32'(bus.b_rvalid), 32'd1);
    checkOutput("bRd7Data", bus.b_rdata, 32'hDEAD_BEEF);

    // A read granted, reset asserted before the closing edge: read is dropped and priority returns to A.
    applyStimulus(1'b1, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    checkOutput("midRdGntA", 32'(bus.a_gnt), 32'd1);
    #2 rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 3, 0);
    @(negedge clk);
    checkOutput("midRdDropped", 32'(bus.a_rvalid), 32'd0);
    checkOutput("midRdPrioA", 32'(bus.a_gnt), 32'd1);
    checkOutput("midRdPrioB", 32'(bus.b_gnt), 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    done = 1'b1;
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/blram_arbiter.md
# blram_arbiter

Two-port arbiter that shares the single-port `blram` between two requesters: port A (the `VerySimpleCPU` memory port) and port B (a loader/debug master). Each cycle at most one request is granted and forwarded to the RAM. For granted reads, the RAM's one-cycle-latency registered output is returned to the requester that issued it, flagged by a read-valid strobe. The block sits between the masters and `blram`, replacing the direct CPU-to-RAM connection.

## Interface
- `ADDR_W`, 14: address width; matches the RAM's `SIZE`.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `a_req`  in  1  port A request; held until `a_gnt`.
- `a_we`  in  1  port A write enable; qualified by `a_req`.
- `a_addr`  in  ADDR_W  port A address.
- `a_wdata`  in  DATA_W  port A write data.
- `a_gnt`  out  1  port A granted this cycle (combinational).
- `a_rvalid`  out  1  port A read data valid (registered).
- `a_rdata`  out  DATA_W  port A read data.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as port A, for port B.
- `mem_we`  out  1  to RAM `i_we`.
- `mem_addr`  out  ADDR_W  to RAM `i_addr`.
- `mem_wdata`  out  DATA_W  to RAM `i_ram_data_in`.
- `mem_rdata`  in  DATA_W  from RAM `o_ram_data_out`.

## Operation
- Arbitration is combinational on the current `a_req`/`b_req` and the registered priority pointer `prio`.
  - `prio` values are A or B.
  - Exactly one of `a_gnt`/`b_gnt` is high when any request is high. Neither is high when no request is high.
- Grant rules:
  - Only one port requesting: that port is granted, regardless of `prio`.
  - Both ports requesting: the port named by `prio` is granted.
- Pointer update on a clock edge with a grant: `prio` moves to the non-granted port. With no grant, `prio` holds.
- RAM drive:
  - The granted port's `we`/`addr`/`wdata` are muxed onto `mem_*`.
  - With no grant: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Read tracking: a registered two-bit tag (`rd_a`, `rd_b`) records a granted read (`gnt & ~we`). The tag drives `x_rvalid` in the following cycle.
- Read data: `a_rdata` and `b_rdata` are both wired to `mem_rdata`. They are meaningful only while the corresponding `rvalid` is high.
- Writes: a granted write produces no `rvalid`.
- Ungranted requester: must hold `req`, `we`, `addr` and `wdata` stable until granted. The arbiter keeps no request queue.

## Timing
- Reset state, in the cycle after the edge with `rst`=0:
  - `prio`=A.
  - `a_rvalid`=`b_rvalid`=0.
  - The grant/`mem_*` outputs are forced to 0 while `rst`=0.
- Grant latency: 0 cycles (same cycle as `req`).
- Read latency: a read granted in cycle t gives `x_rvalid`=1 in cycle t+1, with `mem_rdata` holding `memory[addr]`.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed when the other port is idle.
- Write then read to the same address in cycles t and t+1: the read in t+2 returns the new data, because the RAM write lands at the end of t.
- Read and write on the same cycle are impossible; at most one grant.
- Reset mid-read: if `rst`=0 at the edge after a read grant, `rvalid` stays 0 and the read is dropped.
- Under continuous contention, grants strictly alternate A, B, A, B… Worst-case wait is 1 cycle.

## Configuration
- `BLRAM_ARB_RR_EN`:
  - Defined: round-robin behaviour as described above.
  - Undefined: fixed priority. Port A always wins when both request, the `prio` register is removed, and port B may starve.
  - All other behaviour is identical in both builds.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with both `req`=1 → all `gnt`/`rvalid`/`mem_we` read 0. On the first cycle after reset, with both requesting, `a_gnt`=1.
- Single port write then read:
  - B writes addr 50 data 0x0000_00AB in cycle t → `mem_we`=1, `mem_addr`=50.
  - B reads addr 50 in t+1 → `b_rvalid`=1 and `b_rdata`=0xAB in t+2. `a_rvalid` stays 0.
- Contention: both ports read continuously (A addr 10, B addr 20) for 6 cycles → grants A,B,A,B,A,B. Each `rvalid` pulses every other cycle with the correct data. Without `BLRAM_ARB_RR_EN`: A granted all 6 cycles and `b_rvalid` never asserts.
- Idle port: only A requests reads of addrs 0..3 back-to-back → `a_gnt`=1 for 4 consecutive cycles and `a_rvalid`=1 for the next 4.
- Write gives no valid: A writes addr 7 → `a_rvalid`=0 in the following cycle. A subsequent B read of addr 7 returns A's data.
- Reset mid-read: A read granted in cycle t with `rst`=0 at the end of t → `a_rvalid`=0 in t+1 and `prio` returns to A.
